// File: rtl/sd_karte_schreiber.sv
// sd_karte_schreiber
// Word-granular SD write port. A 32-bit word write is done as a
// read-modify-write of the containing 512-byte sector. The sector is read
// into a local byte buffer. It is then streamed back to the controller, and
// the four addressed bytes are replaced on the fly by the latched data word.
// The buffer itself is never modified by the merge.

module sd_karte_schreiber #(
  parameter int SEKTOR_BITS = 14
) (
  input  logic        Clock,
  input  logic        Reset,
  // CPU side
  input  logic [31:0] Adresse,
  input  logic [31:0] Daten,
  input  logic        Schreiben,
  output logic        Busy,
  output logic        Fertig,
  output logic [3:0]  zustand,
  // SD controller side
  input  logic        sd_ready,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_address,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic [7:0]  sd_din,
  input  logic        sd_ready_for_next_byte
);

  typedef enum logic [3:0] {
    INIT             = 4'd0,
    IDLE             = 4'd1,
    LESEN            = 4'd2,
    LESEN_WARTEN     = 4'd3,
    SCHREIBEN_START  = 4'd4,
    SCHREIBEN        = 4'd5,
    SCHREIBEN_WARTEN = 4'd6
  } zustand_t;

  // Returns the byte to send for sector offset 'index': the buffered byte,
  // or the matching byte of the latched word (big-endian) when the offset
  // falls inside the addressed word.
  function automatic logic [7:0] merge_byte(
    input logic [7:0]  puffer,
    input logic [9:0]  index,
    input logic [6:0]  wort,
    input logic [31:0] daten
  );
    logic [7:0] ergebnis;
    if (index[8:2] == wort) begin
      case (index[1:0])
        2'd0:    ergebnis = daten[31:24];
        2'd1:    ergebnis = daten[23:16];
        2'd2:    ergebnis = daten[15:8];
        2'd3:    ergebnis = daten[7:0];
        default: ergebnis = daten[7:0];
      endcase
    end else begin
      ergebnis = puffer;
    end
    return ergebnis;
  endfunction

  // State and registered outputs
  zustand_t    zustand_q;
  logic [9:0]  zaehler_q;
  logic [6:0]  wort_q;
  logic [31:0] daten_q;
  logic [31:0] sd_address_q;
  logic        busy_q;
  logic        fertig_q;
  logic        sd_rd_q;
  logic        sd_wr_q;
  logic [7:0]  sd_din_q;

  // Previous levels of the controller strobes, for rising-edge detection
  logic        verfuegbar_q;
  logic        naechstes_q;

  // Sector buffer
  logic [7:0]  buffer_q [512];

  // Combinational helpers
  logic        lese_flanke_s;
  logic        schreib_flanke_s;
  logic        puffer_schreiben_s;
  logic [7:0]  puffer_lese_s;
  logic [7:0]  merge_d;
  logic [31:0] sd_address_d;
  logic        adresse_unused_s;

  // Upper address bits beyond the sector field are not used for addressing.
  assign adresse_unused_s = ^Adresse[31:7+SEKTOR_BITS];

  // Byte address of the sector: zero-padded sector index followed by 9 zero bits.
  assign sd_address_d = 32'({Adresse[7+SEKTOR_BITS-1:7], 9'b0});

  // Edge detection, buffer write enable and merged outgoing byte.
  always_comb begin
    lese_flanke_s      = sd_byte_available & ~verfuegbar_q;
    schreib_flanke_s   = sd_ready_for_next_byte & ~naechstes_q;
    puffer_schreiben_s = (zustand_q == LESEN) & lese_flanke_s & ~zaehler_q[9];
    puffer_lese_s      = buffer_q[zaehler_q[8:0]];
    merge_d            = merge_byte(puffer_lese_s, zaehler_q, wort_q, daten_q);
  end

  // Register the strobe levels so each byte is counted once per rising edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      verfuegbar_q <= 1'b0;
      naechstes_q  <= 1'b0;
    end else begin
      verfuegbar_q <= sd_byte_available;
      naechstes_q  <= sd_ready_for_next_byte;
    end
  end

  // Sector buffer: filled only while reading, contents need no reset.
  always_ff @(posedge Clock) begin
    if (puffer_schreiben_s) begin
      buffer_q[zaehler_q[8:0]] <= sd_dout;
    end
  end

  // Main sequencer: read sector, then write it back with the word merged in.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_q    <= INIT;
      zaehler_q    <= 10'd0;
      wort_q       <= 7'd0;
      daten_q      <= 32'd0;
      sd_address_q <= 32'd0;
      busy_q       <= 1'b1;
      fertig_q     <= 1'b0;
      sd_rd_q      <= 1'b0;
      sd_wr_q      <= 1'b0;
      sd_din_q     <= 8'd0;
    end else begin
      fertig_q <= 1'b0;
      case (zustand_q)
        INIT: begin
          busy_q  <= 1'b1;
          sd_rd_q <= 1'b0;
          sd_wr_q <= 1'b0;
          if (sd_ready) begin
            busy_q    <= 1'b0;
            zustand_q <= IDLE;
          end
        end

        IDLE: begin
          // Requests while the controller is not ready are dropped, not queued.
          if (Schreiben && sd_ready) begin
            wort_q       <= Adresse[6:0];
            daten_q      <= Daten;
            sd_address_q <= sd_address_d;
            zaehler_q    <= 10'd0;
            busy_q       <= 1'b1;
            sd_rd_q      <= 1'b1;
            zustand_q    <= LESEN;
          end
        end

        LESEN: begin
          // Bit 9 of the counter marks the full 512-byte sector.
          if (zaehler_q[9]) begin
            sd_rd_q   <= 1'b0;
            zustand_q <= LESEN_WARTEN;
          end else if (lese_flanke_s) begin
            zaehler_q <= zaehler_q + 10'd1;
          end
        end

        LESEN_WARTEN: begin
          if (sd_ready) begin
            zaehler_q <= 10'd0;
            zustand_q <= SCHREIBEN_START;
          end
        end

        SCHREIBEN_START: begin
          // Present byte 0 one cycle before the write request rises.
          sd_din_q  <= merge_d;
          zustand_q <= SCHREIBEN;
        end

        SCHREIBEN: begin
          if (zaehler_q[9]) begin
            sd_wr_q   <= 1'b0;
            zustand_q <= SCHREIBEN_WARTEN;
          end else begin
            // sd_din follows the counter with one cycle of latency; the
            // controller samples it much later than that.
            sd_wr_q  <= 1'b1;
            sd_din_q <= merge_d;
            if (schreib_flanke_s) begin
              zaehler_q <= zaehler_q + 10'd1;
            end
          end
        end

        SCHREIBEN_WARTEN: begin
          if (sd_ready) begin
            fertig_q  <= 1'b1;
            busy_q    <= 1'b0;
            zustand_q <= IDLE;
          end
        end

        default: begin
          busy_q    <= 1'b1;
          sd_rd_q   <= 1'b0;
          sd_wr_q   <= 1'b0;
          zustand_q <= INIT;
        end
      endcase
    end
  end

  assign Busy       = busy_q;
  assign Fertig     = fertig_q;
  assign zustand    = zustand_q;
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign sd_address = sd_address_q;
  assign sd_din     = sd_din_q;

endmodule

// File: tb/tb_sd_karte_schreiber.sv
// Self-checking bench for sd_karte_schreiber. A behavioural SD controller
// serves a sector image and records the bytes written back. The expected
// sector is the image with the addressed word substituted.

module tb_sd_karte_schreiber;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] Adresse;
  logic [31:0] Daten;
  logic        Schreiben;
  logic        Busy;
  logic        Fertig;
  logic [3:0]  zustand;
  logic        sd_ready;
  logic        sd_rd;
  logic        sd_wr;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_available;
  logic [7:0]  sd_din;
  logic        sd_ready_for_next_byte;

  sd_karte_schreiber #(.SEKTOR_BITS(14)) dut (
    .Clock                  (Clock),
    .Reset                  (Reset),
    .Adresse                (Adresse),
    .Daten                  (Daten),
    .Schreiben              (Schreiben),
    .Busy                   (Busy),
    .Fertig                 (Fertig),
    .zustand                (zustand),
    .sd_ready               (sd_ready),
    .sd_rd                  (sd_rd),
    .sd_wr                  (sd_wr),
    .sd_address             (sd_address),
    .sd_dout                (sd_dout),
    .sd_byte_available      (sd_byte_available),
    .sd_din                 (sd_din),
    .sd_ready_for_next_byte (sd_ready_for_next_byte)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Shared between main sequence and controller model
  logic [7:0] sector_img [512];
  logic [7:0] captured [$];
  bit         ctl_hold  = 1'b1;
  bit         ctl_busy  = 1'b0;
  int         hold_mode = 0;
  int         wr_ops    = 0;
  int         fertig_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Controller model: advance n cycles, acting 1 time unit after the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clock);
      #1;
    end
  endtask

  function automatic int pulse_len();
    return (hold_mode > 0) ? hold_mode : int'($urandom_range(1, 3));
  endfunction

  // Behavioural SD controller.
  initial begin
    int bound;
    sd_ready = 1'b0;
    sd_byte_available = 1'b0;
    sd_ready_for_next_byte = 1'b0;
    sd_dout = 8'd0;
    forever begin
      tick(1);
      if (ctl_hold) begin
        sd_ready = 1'b0;
        sd_byte_available = 1'b0;
        sd_ready_for_next_byte = 1'b0;
        ctl_busy = 1'b0;
      end else if (sd_rd === 1'b1) begin
        ctl_busy = 1'b1;
        sd_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
          if (ctl_hold) break;
          tick(int'($urandom_range(1, 3)));
          sd_dout = sector_img[i];
          sd_byte_available = 1'b1;
          tick(pulse_len());
          sd_byte_available = 1'b0;
        end
        bound = 0;
        while (sd_rd === 1'b1 && bound < 2000 && !ctl_hold) begin
          tick(1);
          bound++;
        end
        tick(int'($urandom_range(2, 6)));
        if (!ctl_hold) sd_ready = 1'b1;
        ctl_busy = 1'b0;
      end else if (sd_wr === 1'b1) begin
        ctl_busy = 1'b1;
        sd_ready = 1'b0;
        captured.delete();
        for (int i = 0; i < 512; i++) begin
          if (ctl_hold) break;
          tick(int'($urandom_range(1, 3)));
          captured.push_back(sd_din);
          sd_ready_for_next_byte = 1'b1;
          tick(pulse_len());
          sd_ready_for_next_byte = 1'b0;
        end
        bound = 0;
        while (sd_wr === 1'b1 && bound < 2000 && !ctl_hold) begin
          tick(1);
          bound++;
        end
        tick(int'($urandom_range(2, 6)));
        if (!ctl_hold) begin
          sd_ready = 1'b1;
          wr_ops++;
        end
        ctl_busy = 1'b0;
      end else begin
        sd_ready = 1'b1;
      end
    end
  end

  // Count Fertig pulses, sampled clear of the rising edge.
  initial begin
    forever begin
      @(posedge Clock);
      #2;
      if (Fertig === 1'b1) fertig_seen++;
    end
  end

  function automatic logic [31:0] exp_addr(input logic [31:0] adr);
    return ((adr >> 7) & 32'h0000_3FFF) << 9;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 512; i++) sector_img[i] = 8'($urandom());
  endtask

  // One write transaction, called at a falling edge. Optional stray requests
  // while busy, optional reset once 'abort_at' bytes have been written back.
  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat,
                          input bit pulse, input int abort_at);
    int fert0, ops0, cyc, bad, base, bound;
    bit done, p2, p5;
    logic [7:0] exp_b;
    fert0 = fertig_seen;
    ops0  = wr_ops;
    done = 1'b0; p2 = 1'b0; p5 = 1'b0;
    Adresse = adr; Daten = dat; Schreiben = 1'b1;
    @(negedge Clock);
    Schreiben = 1'b0;
    check("accept_busy", 32'(Busy), 32'd1);
    check("accept_rd", 32'(sd_rd), 32'd1);
    check("sd_address", sd_address, exp_addr(adr));
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge Clock);
      cyc++;
      Schreiben = 1'b0;
      if (Fertig === 1'b1) begin
        done = 1'b1;
      end else if (abort_at > 0 && zustand === 4'd5 && captured.size() >= abort_at) begin
        Reset = 1'b1;
        ctl_hold = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("rst_mid_wr", 32'(sd_wr), 32'd0);
        check("rst_mid_busy", 32'(Busy), 32'd1);
        check("rst_mid_state", 32'(zustand), 32'd0);
        bound = 0;
        while (ctl_busy && bound < 100) begin
          @(negedge Clock);
          bound++;
        end
        repeat (3) @(negedge Clock);
        check("rst_wait_state", 32'(zustand), 32'd0);
        ctl_hold = 1'b0;
        @(negedge Clock);
        check("rst_idle_state", 32'(zustand), 32'd1);
        check("rst_no_writeback", 32'(wr_ops - ops0), 32'd0);
        return;
      end else if (pulse && !p2 && zustand === 4'd2) begin
        Schreiben = 1'b1; Adresse = $urandom(); Daten = $urandom(); p2 = 1'b1;
      end else if (pulse && !p5 && zustand === 4'd5) begin
        Schreiben = 1'b1; Adresse = $urandom(); Daten = $urandom(); p5 = 1'b1;
      end
    end
    check("fertig_seen", 32'(done), 32'd1);
    check("fertig_busy_low", 32'(Busy), 32'd0);
    check("addr_held", sd_address, exp_addr(adr));
    @(negedge Clock);
    check("fertig_one_cycle", 32'(Fertig), 32'd0);
    check("fertig_pulses", 32'(fertig_seen - fert0), 32'd1);
    check("sector_writes", 32'(wr_ops - ops0), 32'd1);
    check("bytes_sent", 32'(captured.size()), 32'd512);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      exp_b = sector_img[i];
      if (i / 4 == int'(adr[6:0])) exp_b = 8'(dat >> (8 * (3 - (i % 4))));
      if (i >= captured.size()) bad++;
      else if (captured[i] !== exp_b) bad++;
    end
    check("bad_bytes", 32'(bad), 32'd0);
    if (captured.size() == 512) begin
      base = int'(adr[6:0]) * 4;
      check("word_byte0", 32'(captured[base]),     32'(dat[31:24]));
      check("word_byte1", 32'(captured[base + 1]), 32'(dat[23:16]));
      check("word_byte2", 32'(captured[base + 2]), 32'(dat[15:8]));
      check("word_byte3", 32'(captured[base + 3]), 32'(dat[7:0]));
    end
  endtask

  initial begin
    int stay_bad;
    Reset = 1'b1; Schreiben = 1'b0; Adresse = 32'd0; Daten = 32'd0;
    for (int i = 0; i < 512; i++) sector_img[i] = 8'd0;
    repeat (3) @(negedge Clock);
    check("rst_busy", 32'(Busy), 32'd1);
    check("rst_fertig", 32'(Fertig), 32'd0);
    check("rst_rd", 32'(sd_rd), 32'd0);
    check("rst_wr", 32'(sd_wr), 32'd0);
    check("rst_din", 32'(sd_din), 32'd0);
    check("rst_state", 32'(zustand), 32'd0);

    // Controller not ready for 10 cycles: stay in INIT, busy.
    Reset = 1'b0;
    stay_bad = 0;
    repeat (10) begin
      @(negedge Clock);
      if (Busy !== 1'b1 || zustand !== 4'd0) stay_bad++;
    end
    check("init_wait", 32'(stay_bad), 32'd0);
    ctl_hold = 1'b0;
    @(negedge Clock);
    check("init_to_idle", 32'(zustand), 32'd1);
    check("init_busy_low", 32'(Busy), 32'd0);

    // Request while the controller is not ready is dropped.
    ctl_hold = 1'b1;
    repeat (2) @(negedge Clock);
    Adresse = 32'h0000_0183; Daten = 32'h1234_5678; Schreiben = 1'b1;
    @(negedge Clock);
    Schreiben = 1'b0;
    check("notready_busy", 32'(Busy), 32'd0);
    check("notready_rd", 32'(sd_rd), 32'd0);
    check("notready_state", 32'(zustand), 32'd1);
    ctl_hold = 1'b0;
    @(negedge Clock);

    // Sector 3 with identity pattern, word 3.
    for (int i = 0; i < 512; i++) sector_img[i] = 8'(i);
    do_write(32'h0000_0183, 32'hDEAD_BEEF, 1'b0, 0);

    // First and last word of a sector.
    fill_random();
    do_write($urandom() & ~32'h7F, $urandom(), 1'b0, 0);
    fill_random();
    do_write($urandom() | 32'h7F, $urandom(), 1'b0, 0);

    // Strobes held high for 3 cycles per byte.
    hold_mode = 3;
    fill_random();
    do_write($urandom(), $urandom(), 1'b0, 0);
    hold_mode = 0;

    // Stray requests while reading and writing.
    fill_random();
    do_write($urandom(), $urandom(), 1'b1, 0);

    // Reset during write-back, then a clean write.
    fill_random();
    do_write($urandom(), $urandom(), 1'b0, 200);
    fill_random();
    do_write($urandom(), $urandom(), 1'b0, 0);

    // A few back-to-back random writes.
    repeat (3) begin
      fill_random();
      do_write($urandom(), $urandom(), 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
